// File: rtl/dice_pkg.sv
// -----------------------------------------------------------------------------
// dice_pkg
//   Shared types and constants for the two-player "pig" dice turn controller.
//   Contents:
//     state_e    - turn controller FSM state encoding
//     DIE_W      - width of a die value from the roller
//     DIE_MIN    - lowest legal die face
//     DIE_MAX    - highest legal die face (also the "six" tracked by the
//                  optional double-six bust feature, DOUBLE_SIX_BUST_EN)
//     BUST_VAL   - face that busts the current turn
//     die_legal  - helper: is a captured die value a legal face
// -----------------------------------------------------------------------------
package dice_pkg;

    typedef enum logic [2:0] {
        DECIDE = 3'd0,
        ARM    = 3'd1,
        WAIT   = 3'd2,
        SCORE  = 3'd3,
        BANK   = 3'd4,
        OVER   = 3'd5
    } state_e;

    localparam int               DIE_W    = 3;
    localparam logic [DIE_W-1:0] DIE_MIN  = 3'd1;
    localparam logic [DIE_W-1:0] DIE_MAX  = 3'd6;
    localparam logic [DIE_W-1:0] BUST_VAL = 3'd1;

    // A captured value outside 1..6 is roller noise and must be discarded.
    function automatic logic die_legal(input logic [DIE_W-1:0] value);
        return (value >= DIE_MIN) && (value <= DIE_MAX);
    endfunction

endpackage

// File: rtl/dice_turn_ctrl_sat_add.sv
// -----------------------------------------------------------------------------
// sat_add
//   Unsigned saturating adder. The operand is zero-extended from OPND_W to
//   SCORE_W bits; a carry out of SCORE_W bits clamps the result to all ones,
//   so scores never wrap.
//   Parameters:
//     SCORE_W - width of the base value and the result
//     OPND_W  - width of the operand (must not exceed SCORE_W)
//   Ports:
//     base  in  SCORE_W  accumulated value
//     opnd  in  OPND_W   value to add
//     sum   out SCORE_W  saturated sum
// -----------------------------------------------------------------------------
module sat_add #(
    parameter int SCORE_W = 8,
    parameter int OPND_W  = 3
) (
    input  logic [SCORE_W-1:0] base,
    input  logic [OPND_W-1:0]  opnd,
    output logic [SCORE_W-1:0] sum
);

    localparam int EXT_W = SCORE_W + 1;

    logic [EXT_W-1:0] wide_s;

    assign wide_s = EXT_W'(base) + EXT_W'(opnd);

    // Clamp on carry-out, pass the low bits through otherwise.
    always_comb begin
        if (wide_s[SCORE_W]) begin
            sum = {SCORE_W{1'b1}};
        end else begin
            sum = wide_s[SCORE_W-1:0];
        end
    end

endmodule

// File: rtl/dice_turn_ctrl.sv
// -----------------------------------------------------------------------------
// dice_turn_ctrl
//   Game-side initiator for the die roller's enable/choose handshake,
//   implementing two-player "pig": rolls add to the turn total, a 1 busts the
//   turn and passes play, a hold banks the turn total into the active
//   player's score. Reaching WIN_SCORE on a bank ends the game.
//
//   Optional build macro:
//     DOUBLE_SIX_BUST_EN - when defined, two consecutive 6s in one turn bust
//                          the turn like a 1 does.
//
//   Parameters:
//     SCORE_W   - width of turn total and scores (saturating)
//     WIN_SCORE - banked score that wins the game
//
//   Ports:
//     clk          in   system clock
//     rst_n        in   synchronous active-low reset
//     roll_num     in   die value from the roller (legal 1..6)
//     roll_choose  in   roller result-valid level
//     roll_req     in   pulse: active player requests a roll
//     hold_req     in   pulse: active player banks the turn total
//     new_game     in   pulse: clear everything, player 0 starts
//     enable       out  roller enable; rising edge starts a roll
//     player       out  active player
//     last_roll    out  last captured die value, 0 = none
//     turn_total   out  current unbanked total
//     score0       out  banked score of player 0
//     score1       out  banked score of player 1
//     busy         out  roll in flight
//     game_over    out  game finished
//     winner       out  winning player, valid while game_over
// -----------------------------------------------------------------------------
module dice_turn_ctrl
    import dice_pkg::*;
#(
    parameter int SCORE_W   = 8,
    parameter int WIN_SCORE = 100
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [DIE_W-1:0]   roll_num,
    input  logic               roll_choose,
    input  logic               roll_req,
    input  logic               hold_req,
    input  logic               new_game,
    output logic               enable,
    output logic               player,
    output logic [DIE_W-1:0]   last_roll,
    output logic [SCORE_W-1:0] turn_total,
    output logic [SCORE_W-1:0] score0,
    output logic [SCORE_W-1:0] score1,
    output logic               busy,
    output logic               game_over,
    output logic               winner
);

    localparam logic [31:0] WIN_LIM = 32'(WIN_SCORE);

    state_e               state_r,      state_s;
    logic                 player_r,     player_s;
    logic [DIE_W-1:0]     last_roll_r,  last_roll_s;
    logic [SCORE_W-1:0]   turn_total_r, turn_total_s;
    logic [SCORE_W-1:0]   score0_r,     score0_s;
    logic [SCORE_W-1:0]   score1_r,     score1_s;
    logic                 winner_r,     winner_s;
    logic                 enable_r,     enable_s;
    logic                 busy_r,       busy_s;
    logic                 game_over_r,  game_over_s;
`ifdef DOUBLE_SIX_BUST_EN
    logic                 six_seen_r,   six_seen_s;
`endif

    logic [SCORE_W-1:0]   turn_sum_s;
    logic [SCORE_W-1:0]   bank_base_s;
    logic [SCORE_W-1:0]   bank_sum_s;

    assign bank_base_s = player_r ? score1_r : score0_r;

    sat_add #(
        .SCORE_W (SCORE_W),
        .OPND_W  (DIE_W)
    ) u_turn_add (
        .base (turn_total_r),
        .opnd (last_roll_r),
        .sum  (turn_sum_s)
    );

    sat_add #(
        .SCORE_W (SCORE_W),
        .OPND_W  (SCORE_W)
    ) u_bank_add (
        .base (bank_base_s),
        .opnd (turn_total_r),
        .sum  (bank_sum_s)
    );

    // Next-state and next-register values for the turn FSM.
    always_comb begin
        state_s      = state_r;
        player_s     = player_r;
        last_roll_s  = last_roll_r;
        turn_total_s = turn_total_r;
        score0_s     = score0_r;
        score1_s     = score1_r;
        winner_s     = winner_r;
`ifdef DOUBLE_SIX_BUST_EN
        six_seen_s   = six_seen_r;
`endif

        if (new_game) begin
            // Overrides everything, including a result arriving this cycle.
            state_s      = DECIDE;
            player_s     = 1'b0;
            last_roll_s  = {DIE_W{1'b0}};
            turn_total_s = {SCORE_W{1'b0}};
            score0_s     = {SCORE_W{1'b0}};
            score1_s     = {SCORE_W{1'b0}};
            winner_s     = 1'b0;
`ifdef DOUBLE_SIX_BUST_EN
            six_seen_s   = 1'b0;
`endif
        end else begin
            case (state_r)
                DECIDE: begin
                    if (roll_req) begin
                        state_s = ARM;
                    end else if (hold_req) begin
                        state_s = BANK;
                    end else begin
                        state_s = DECIDE;
                    end
                end
                // The roller is flushing its previous result this cycle,
                // so roll_choose is not trusted here.
                ARM: begin
                    state_s = WAIT;
                end
                WAIT: begin
                    if (roll_choose) begin
                        last_roll_s = roll_num;
                        state_s     = SCORE;
                    end else begin
                        state_s = WAIT;
                    end
                end
                SCORE: begin
                    state_s = DECIDE;
                    if (last_roll_r == BUST_VAL) begin
                        turn_total_s = {SCORE_W{1'b0}};
                        player_s     = ~player_r;
`ifdef DOUBLE_SIX_BUST_EN
                        six_seen_s   = 1'b0;
                    end else if ((last_roll_r == DIE_MAX) && six_seen_r) begin
                        turn_total_s = {SCORE_W{1'b0}};
                        player_s     = ~player_r;
                        six_seen_s   = 1'b0;
`endif
                    end else if (die_legal(last_roll_r)) begin
                        turn_total_s = turn_sum_s;
`ifdef DOUBLE_SIX_BUST_EN
                        six_seen_s   = (last_roll_r == DIE_MAX);
`endif
                    end else begin
                        last_roll_s = {DIE_W{1'b0}};
                    end
                end
                BANK: begin
                    turn_total_s = {SCORE_W{1'b0}};
`ifdef DOUBLE_SIX_BUST_EN
                    six_seen_s   = 1'b0;
`endif
                    if (player_r) begin
                        score1_s = bank_sum_s;
                    end else begin
                        score0_s = bank_sum_s;
                    end
                    if (32'(bank_sum_s) >= WIN_LIM) begin
                        winner_s = player_r;
                        state_s  = OVER;
                    end else begin
                        player_s = ~player_r;
                        state_s  = DECIDE;
                    end
                end
                OVER: begin
                    state_s = OVER;
                end
                default: begin
                    state_s = DECIDE;
                end
            endcase
        end
    end

    // Output flags are decoded from the next state so they register with it.
    always_comb begin
        enable_s    = 1'b0;
        busy_s      = 1'b0;
        game_over_s = 1'b0;
        case (state_s)
            ARM, WAIT: begin
                enable_s = 1'b1;
                busy_s   = 1'b1;
            end
            OVER: begin
                game_over_s = 1'b1;
            end
            default: begin
                enable_s    = 1'b0;
                busy_s      = 1'b0;
                game_over_s = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= DECIDE;
            player_r     <= 1'b0;
            last_roll_r  <= {DIE_W{1'b0}};
            turn_total_r <= {SCORE_W{1'b0}};
            score0_r     <= {SCORE_W{1'b0}};
            score1_r     <= {SCORE_W{1'b0}};
            winner_r     <= 1'b0;
            enable_r     <= 1'b0;
            busy_r       <= 1'b0;
            game_over_r  <= 1'b0;
`ifdef DOUBLE_SIX_BUST_EN
            six_seen_r   <= 1'b0;
`endif
        end else begin
            state_r      <= state_s;
            player_r     <= player_s;
            last_roll_r  <= last_roll_s;
            turn_total_r <= turn_total_s;
            score0_r     <= score0_s;
            score1_r     <= score1_s;
            winner_r     <= winner_s;
            enable_r     <= enable_s;
            busy_r       <= busy_s;
            game_over_r  <= game_over_s;
`ifdef DOUBLE_SIX_BUST_EN
            six_seen_r   <= six_seen_s;
`endif
        end
    end

    assign enable     = enable_r;
    assign player     = player_r;
    assign last_roll  = last_roll_r;
    assign turn_total = turn_total_r;
    assign score0     = score0_r;
    assign score1     = score1_r;
    assign busy       = busy_r;
    assign game_over  = game_over_r;
    assign winner     = winner_r;

endmodule
